router_fsm_nch: RTL and testbench

//   Parametrised control FSM for a 1xNUM_CH packet router. Sits between the input register block
//   and NUM_CH output FIFOs/synchronizer. Sequences header decode, payload and parity load,

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fsm_nch.sv | 148 ++++++++++++++
 tb/tb_router_fsm_nch.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// State encoding and default geometry shared by the 1xNUM_CH router control FSM.
package router_pkg;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      FIFO_FULL_STATE    = 4'd3,
      LOAD_AFTER_FULL    = 4'd4,
      LOAD_PARITY        = 4'd5,
      CHECK_PARITY_ERROR = 4'd6,
      WAIT_TILL_EMPTY    = 4'd7,
      DROP_PACKET        = 4'd8
   } state_e;

   localparam int DEF_NUM_CH       = 3;
   localparam int DEF_ADDR_W       = 2;
   localparam int DEF_WAIT_TIMEOUT = 256;

endpackage

// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xNUM_CH packet router; Moore outputs, one cycle from input to state.
// Stalls the source via busy; drops bad-address or timed-out packets with busy low so the source drains.
module router_fsm_nch
   import router_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   input  logic [NUM_CH-1:0] fifo_full,
   input  logic [NUM_CH-1:0] fifo_empty,
   input  logic [NUM_CH-1:0] soft_reset,
   output logic [ADDR_W-1:0] addr_q,
   output logic              busy,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              rst_int_reg,
   output logic              write_enb_reg,
   output logic              drop_state,
   output logic              err_bad_addr,
   output logic              err_timeout
);

   localparam int CNT_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             full_s, empty_s, empty_at_q, empty_at_in, soft_s, addr_ok;
   logic             bad_nxt, timeout_nxt;

   // Channel selection; an address outside 0..NUM_CH-1 selects nothing.
   always_comb begin
      full_s      = 1'b0;
      soft_s      = 1'b0;
      empty_at_q  = 1'b0;
      empty_at_in = 1'b0;
      addr_ok     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            full_s     = fifo_full[i];
            soft_s     = soft_reset[i];
            empty_at_q = fifo_empty[i];
         end
         if (data_in == ADDR_W'(i)) begin
            empty_at_in = fifo_empty[i];
            addr_ok     = 1'b1;
         end
      end
      empty_s = (state == DECODE_ADDRESS) ? empty_at_in : empty_at_q;
   end

   always_comb begin
      state_nxt   = state;
      bad_nxt     = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               if (!addr_ok) begin
                  state_nxt = DROP_PACKET;
                  bad_nxt   = 1'b1;
               end else if (empty_s) begin
                  state_nxt = LOAD_FIRST_DATA;
               end else begin
                  state_nxt = WAIT_TILL_EMPTY;
               end
            end
         end
         LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
         LOAD_DATA: begin
            if (full_s)          state_nxt = FIFO_FULL_STATE;
            else if (!pkt_valid) state_nxt = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!full_s) state_nxt = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_nxt = DECODE_ADDRESS;
            else if (low_pkt_valid) state_nxt = LOAD_PARITY;
            else                    state_nxt = LOAD_DATA;
         end
         LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_nxt = full_s ? FIFO_FULL_STATE : DECODE_ADDRESS;
         WAIT_TILL_EMPTY: begin
            // The channel draining in the same cycle beats the timeout.
            if (empty_s) begin
               state_nxt = LOAD_FIRST_DATA;
            end else if ((WAIT_TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
               state_nxt   = DROP_PACKET;
               timeout_nxt = 1'b1;
            end
         end
         DROP_PACKET: begin
            if (!pkt_valid) state_nxt = DECODE_ADDRESS;
         end
         default: state_nxt = DECODE_ADDRESS;
      endcase

      if (soft_s) begin
         state_nxt   = DECODE_ADDRESS;
         bad_nxt     = 1'b0;
         timeout_nxt = 1'b0;
      end

      if (soft_s || (state != WAIT_TILL_EMPTY)) wait_cnt_nxt = '0;
      else if (wait_cnt != '1)                  wait_cnt_nxt = wait_cnt + CNT_W'(1);
      else                                      wait_cnt_nxt = wait_cnt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= DECODE_ADDRESS;
         addr_q       <= '0;
         wait_cnt     <= '0;
         err_bad_addr <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         err_bad_addr <= bad_nxt;
         err_timeout  <= timeout_nxt;
         if ((state == DECODE_ADDRESS) && pkt_valid) addr_q <= data_in;
      end
   end

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign drop_state    = (state == DROP_PACKET);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
   assign busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                          (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                          (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: three configurations driven from one stimulus stream and tracked by a packet-phase model.
module tb_router_fsm_nch;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, pkt_valid, parity_done, low_pkt_valid;
   logic [2:0] data_in;
   logic [7:0] fifo_full, fifo_empty, soft_reset;
   logic [1:0] a_addr, b_addr;
   logic [2:0] c_addr;
   // {detect, lfd, ld, laf, full, rst_int, write_enb, drop, busy, err_bad_addr, err_timeout}
   wire  [10:0] a_o, b_o, c_o;

   int checks = 0;
   int errors = 0;

   localparam logic [10:0] O_DEC  = 11'b100_0000_0000;
   localparam logic [10:0] O_LFD  = 11'b010_0000_0100;
   localparam logic [10:0] O_LD   = 11'b001_0001_0000;
   localparam logic [10:0] O_FULL = 11'b000_0100_0100;
   localparam logic [10:0] O_LAF  = 11'b000_1001_0100;
   localparam logic [10:0] O_LP   = 11'b000_0001_0100;
   localparam logic [10:0] O_CPE  = 11'b000_0010_0100;
   localparam logic [10:0] O_WAIT = 11'b000_0000_0100;
   localparam logic [10:0] O_DROP = 11'b000_0000_1000;

   router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(256)) u_a (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in[1:0]),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full[2:0]), .fifo_empty(fifo_empty[2:0]), .soft_reset(soft_reset[2:0]),
      .addr_q(a_addr), .busy(a_o[2]), .detect_add(a_o[10]), .lfd_state(a_o[9]), .ld_state(a_o[8]),
      .laf_state(a_o[7]), .full_state(a_o[6]), .rst_int_reg(a_o[5]), .write_enb_reg(a_o[4]),
      .drop_state(a_o[3]), .err_bad_addr(a_o[1]), .err_timeout(a_o[0]));

   router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) u_b (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in[1:0]),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full[2:0]), .fifo_empty(fifo_empty[2:0]), .soft_reset(soft_reset[2:0]),
      .addr_q(b_addr), .busy(b_o[2]), .detect_add(b_o[10]), .lfd_state(b_o[9]), .ld_state(b_o[8]),
      .laf_state(b_o[7]), .full_state(b_o[6]), .rst_int_reg(b_o[5]), .write_enb_reg(b_o[4]),
      .drop_state(b_o[3]), .err_bad_addr(b_o[1]), .err_timeout(b_o[0]));

   router_fsm_nch #(.NUM_CH(8), .ADDR_W(3), .WAIT_TIMEOUT(256)) u_c (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .addr_q(c_addr), .busy(c_o[2]), .detect_add(c_o[10]), .lfd_state(c_o[9]), .ld_state(c_o[8]),
      .laf_state(c_o[7]), .full_state(c_o[6]), .rst_int_reg(c_o[5]), .write_enb_reg(c_o[4]),
      .drop_state(c_o[3]), .err_bad_addr(c_o[1]), .err_timeout(c_o[0]));

   // Packet-phase model: where the current packet is in its life, plus its destination.
   typedef enum {M_IDLE, M_FIRST, M_BODY, M_STALL, M_RESUME, M_PAR, M_CHK, M_WAIT, M_DROP} mode_e;
   typedef struct {
      mode_e md;
      int    addr;
      int    waited;
      bit    ebad;
      bit    eto;
   } mdl_t;

   mdl_t mA, mB, mC;

   function automatic mdl_t mstep(input mdl_t m, input int nch, input int to, input int din);
      mdl_t n;
      bit   full_s, empty_s, soft_s;
      n      = m;
      n.ebad = 1'b0;
      n.eto  = 1'b0;
      if (reset) begin
         n.md = M_IDLE; n.addr = 0; n.waited = 0;
         return n;
      end
      full_s  = (m.addr < nch) && fifo_full[m.addr];
      soft_s  = (m.addr < nch) && soft_reset[m.addr];
      empty_s = (m.md == M_IDLE) ? ((din < nch) && fifo_empty[din])
                                 : ((m.addr < nch) && fifo_empty[m.addr]);
      n.waited = (m.md == M_WAIT) ? m.waited + 1 : 0;
      if (m.md == M_IDLE && pkt_valid) n.addr = din;
      if (soft_s) begin
         n.md = M_IDLE; n.waited = 0;
         return n;
      end
      case (m.md)
         M_IDLE: if (pkt_valid) begin
            if (din >= nch) begin n.md = M_DROP; n.ebad = 1'b1; end
            else n.md = empty_s ? M_FIRST : M_WAIT;
         end
         M_FIRST:  n.md = M_BODY;
         M_BODY:   if (full_s) n.md = M_STALL; else if (!pkt_valid) n.md = M_PAR;
         M_STALL:  if (!full_s) n.md = M_RESUME;
         M_RESUME: n.md = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_BODY);
         M_PAR:    n.md = M_CHK;
         M_CHK:    n.md = full_s ? M_STALL : M_IDLE;
         M_WAIT: begin
            if (empty_s) n.md = M_FIRST;
            else if (to != 0 && m.waited == to - 1) begin n.md = M_DROP; n.eto = 1'b1; end
         end
         M_DROP:   if (!pkt_valid) n.md = M_IDLE;
         default:  n.md = M_IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [10:0] mexp(input mdl_t m);
      logic [10:0] o;
      case (m.md)
         M_IDLE:   o = O_DEC;
         M_FIRST:  o = O_LFD;
         M_BODY:   o = O_LD;
         M_STALL:  o = O_FULL;
         M_RESUME: o = O_LAF;
         M_PAR:    o = O_LP;
         M_CHK:    o = O_CPE;
         M_WAIT:   o = O_WAIT;
         default:  o = O_DROP;
      endcase
      o[1] = m.ebad;
      o[0] = m.eto;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      mA = mstep(mA, 3, 256, int'(data_in[1:0]));
      mB = mstep(mB, 3, 8,   int'(data_in[1:0]));
      mC = mstep(mC, 8, 256, int'(data_in));
      @(posedge clock);
      #1;
      chk("model_a", 16'({3'(a_addr), a_o}), 16'({3'(mA.addr), mexp(mA)}));
      chk("model_b", 16'({3'(b_addr), b_o}), 16'({3'(mB.addr), mexp(mB)}));
      chk("model_c", 16'({c_addr, c_o}),     16'({3'(mC.addr), mexp(mC)}));
   endtask

   task automatic quiet();
      reset = 1'b0; pkt_valid = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
      data_in = 3'd0; fifo_full = 8'h00; fifo_empty = 8'hFF; soft_reset = 8'h00;
   endtask

   task automatic settle(input int n);
      quiet();
      for (int k = 0; k < n; k++) tick();
   endtask

   typedef struct packed {
      logic        pv;
      logic [10:0] exp;
   } vec_t;
   vec_t tbl [8];

   task automatic run_table(input string nm, input logic [2:0] hdr, input bit on_c);
      logic [10:0] act;
      logic [2:0]  act_addr;
      int          wr_n;
      wr_n = 0;
      quiet();
      for (int i = 0; i < 8; i++) begin
         pkt_valid = tbl[i].pv;
         data_in   = (i == 0) ? hdr : 3'd0;
         tick();
         act      = on_c ? c_o : a_o;
         act_addr = on_c ? c_addr : {1'b0, a_addr};
         chk($sformatf("%s_row%0d", nm, i), 16'(act), 16'(tbl[i].exp));
         if (i == 0) chk({nm, "_addr_q"}, 16'(act_addr), 16'(hdr));
         wr_n += int'(act[4]);
      end
      chk({nm, "_write_cycles"}, 16'(wr_n), 16'd5);
   endtask

   initial begin
      int n, eto_n, wr_n;
      tbl[0] = '{1'b1, O_LFD};
      tbl[1] = '{1'b1, O_LD};
      tbl[2] = '{1'b1, O_LD};
      tbl[3] = '{1'b1, O_LD};
      tbl[4] = '{1'b1, O_LD};
      tbl[5] = '{1'b0, O_LP};
      tbl[6] = '{1'b0, O_CPE};
      tbl[7] = '{1'b0, O_DEC};
      mA = '{M_IDLE, 0, 0, 1'b0, 1'b0};
      mB = mA;
      mC = mA;

      // reset state
      quiet();
      reset = 1'b1;
      tick();
      chk("reset_out_a", 16'(a_o), 16'(O_DEC));
      chk("reset_addr_a", 16'(a_addr), 16'd0);
      chk("reset_out_c", 16'(c_o), 16'(O_DEC));

      // basic packet to channel 1
      run_table("pkt3", 3'd1, 1'b0);

      // channel 2 busy for 10 cycles, then drains
      quiet();
      pkt_valid = 1'b1; data_in = 3'd2; fifo_empty = 8'hFB;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("wait_busy%0d", k), 16'(a_o), 16'(O_WAIT));
      end
      fifo_empty = 8'hFF;
      tick();
      chk("wait_to_lfd", 16'(a_o), 16'(O_LFD));
      settle(6);

      // timeout drop with WAIT_TIMEOUT=8
      quiet();
      pkt_valid = 1'b1; data_in = 3'd0; fifo_empty = 8'hFE;
      tick();
      chk("to_wait_entry", 16'(b_o), 16'(O_WAIT));
      n = 0; eto_n = 0; wr_n = 0;
      while (!b_o[3] && n < 20) begin
         tick();
         n++;
         eto_n += int'(b_o[0]);
         wr_n  += int'(b_o[4]);
      end
      chk("to_drop_delay", 16'(n), 16'd8);
      chk("to_drop_first", 16'(b_o), 16'(O_DROP | 11'd1));
      tick();
      eto_n += int'(b_o[0]);
      chk("to_drop_hold", 16'(b_o), 16'(O_DROP));
      pkt_valid = 1'b0;
      tick();
      chk("to_back_decode", 16'(b_o), 16'(O_DEC));
      chk("to_pulse_count", 16'(eto_n), 16'd1);
      chk("to_no_writes", 16'(wr_n), 16'd0);
      settle(6);

      // bad header address
      quiet();
      pkt_valid = 1'b1; data_in = 3'd3;
      tick();
      chk("bad_addr_drop", 16'(a_o), 16'(O_DROP | 11'd2));
      tick();
      chk("bad_addr_hold", 16'(a_o), 16'(O_DROP));
      pkt_valid = 1'b0;
      tick();
      chk("bad_addr_done", 16'(a_o), 16'(O_DEC));
      settle(4);

      // other-channel full/soft reset ignored; full, after-full, soft reset
      quiet();
      pkt_valid = 1'b1; data_in = 3'd0;
      tick();
      chk("sel_lfd", 16'(a_o), 16'(O_LFD));
      tick();
      chk("sel_ld", 16'(a_o), 16'(O_LD));
      fifo_full = 8'b010; soft_reset = 8'b100;
      tick();
      chk("sel_ignore_other", 16'(a_o), 16'(O_LD));
      fifo_full = 8'b001; soft_reset = 8'b000;
      tick();
      chk("sel_full", 16'(a_o), 16'(O_FULL));
      tick();
      chk("sel_full_hold", 16'(a_o), 16'(O_FULL));
      fifo_full = 8'b000;
      tick();
      chk("sel_laf", 16'(a_o), 16'(O_LAF));
      tick();
      chk("sel_laf_to_ld", 16'(a_o), 16'(O_LD));
      fifo_full = 8'b001;
      tick();
      chk("sel_full_again", 16'(a_o), 16'(O_FULL));
      soft_reset = 8'b001;
      tick();
      chk("sel_soft_reset", 16'(a_o), 16'(O_DEC));
      settle(6);

      // reset in the middle of a payload
      quiet();
      pkt_valid = 1'b1; data_in = 3'd2;
      tick(); tick(); tick();
      chk("mid_ld", 16'(a_o), 16'(O_LD));
      reset = 1'b1;
      tick();
      chk("mid_reset_out", 16'(a_o), 16'(O_DEC));
      chk("mid_reset_addr", 16'(a_addr), 16'd0);
      quiet();

      // eight-channel configuration, highest address
      run_table("pkt8", 3'd7, 1'b1);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset         = ($urandom_range(0, 63) == 0);
         pkt_valid     = ($urandom_range(0, 3) != 0);
         parity_done   = ($urandom_range(0, 7) == 0);
         low_pkt_valid = ($urandom_range(0, 7) == 0);
         data_in       = 3'($urandom_range(0, 7));
         for (int b = 0; b < 8; b++) begin
            fifo_full[b]  = ($urandom_range(0, 3) == 0);
            fifo_empty[b] = ($urandom_range(0, 3) != 0);
            soft_reset[b] = ($urandom_range(0, 31) == 0);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
